// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO controller: write pointer, RAM strobe/address, registered full/almost-full/level/overflow.
// Define FIFO_WR_GRAY_EN for dual-clock use (Gray wr_ptr, synchronised Gray rd_ptr); default is binary, same-clock.
module fifo_wr_ctrl #(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned AFULL_TH    = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              wr_clk,
   input  logic              wr_rst,
   input  logic              wr_en,
   input  logic              ov_clr,
   input  logic [ADDR_W:0]   rd_ptr,
   output logic              wr_ram_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W:0]   wr_ptr,
   output logic              o_fifo_full,
   output logic              o_almost_full,
   output logic [ADDR_W:0]   o_level,
   output logic              o_overflow
);

   localparam int unsigned PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] DEPTH     = PTR_W'(1 << ADDR_W);
   localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'((1 << ADDR_W) - AFULL_TH);

   logic [PTR_W-1:0] wbin_q, wbin_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] level_q, level_d;
   logic [PTR_W-1:0] rsync_bin;
   logic             full_q, full_d;
   logic             afull_q, afull_d;
   logic             ovf_q, ovf_d;
   logic             accept;

`ifdef FIFO_WR_GRAY_EN
   logic [PTR_W-1:0] sync_q [SYNC_STAGES];

   function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
      logic [PTR_W-1:0] b;
      b[PTR_W-1] = g[PTR_W-1];
      for (int i = PTR_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= rd_ptr;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign rsync_bin = gray2bin(sync_q[SYNC_STAGES-1]);
   assign wr_ptr_d  = wbin_d ^ (wbin_d >> 1);
`else
   assign rsync_bin = rd_ptr;
   assign wr_ptr_d  = wbin_d;
`endif

   // Strobe is masked during reset so every output reads 0 while wr_rst is high.
   assign accept    = wr_en & ~full_q;
   assign wr_ram_en = accept & ~wr_rst;

   always_comb begin
      wbin_d  = wbin_q;
      if (accept) wbin_d = wbin_q + PTR_W'(1);
      // Status is derived from the post-accept pointer, so full is never late for the next write.
      level_d = wbin_d - rsync_bin;
      full_d  = (level_d == DEPTH);
      afull_d = (level_d >= AFULL_LVL);
      ovf_d   = (wr_en & full_q) | (ovf_q & ~ov_clr);
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         wbin_q   <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
      end
   end

   assign wr_addr       = wbin_q[ADDR_W-1:0];
   assign wr_ptr        = wr_ptr_q;
   assign o_fifo_full   = full_q;
   assign o_almost_full = afull_q;
   assign o_level       = level_q;
   assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl (ADDR_W=3, AFULL_TH=2, SYNC_STAGES=2), binary or Gray build.
module tb_fifo_wr_ctrl;

`ifdef FIFO_WR_GRAY_EN
   localparam bit GRAY = 1'b1;
`else
   localparam bit GRAY = 1'b0;
`endif

   logic       wr_clk = 1'b0;
   logic       wr_rst;
   logic       wr_en;
   logic       ov_clr;
   logic [3:0] rd_ptr;
   logic       wr_ram_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_ptr;
   logic       o_fifo_full;
   logic       o_almost_full;
   logic [3:0] o_level;
   logic       o_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_wr_ctrl #(.ADDR_W(3), .AFULL_TH(2), .SYNC_STAGES(2)) dut (
      .wr_clk        (wr_clk),
      .wr_rst        (wr_rst),
      .wr_en         (wr_en),
      .ov_clr        (ov_clr),
      .rd_ptr        (rd_ptr),
      .wr_ram_en     (wr_ram_en),
      .wr_addr       (wr_addr),
      .wr_ptr        (wr_ptr),
      .o_fifo_full   (o_fifo_full),
      .o_almost_full (o_almost_full),
      .o_level       (o_level),
      .o_overflow    (o_overflow)
   );

   always #5 wr_clk = ~wr_clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic ram_en, input logic [2:0] addr,
                            input logic [3:0] ptr, input logic full, input logic afull,
                            input logic [3:0] lvl, input logic ovf);
      check({tag, ".wr_ram_en"}, 16'(wr_ram_en), 16'(ram_en));
      check({tag, ".wr_addr"},   16'(wr_addr),   16'(addr));
      check({tag, ".wr_ptr"},    16'(wr_ptr),    16'(ptr));
      check({tag, ".full"},      16'(o_fifo_full),   16'(full));
      check({tag, ".afull"},     16'(o_almost_full), 16'(afull));
      check({tag, ".level"},     16'(o_level),   16'(lvl));
      check({tag, ".overflow"},  16'(o_overflow), 16'(ovf));
   endtask

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   // Hand-computed Gray codes of binary 0..8.
   logic [3:0] gray_tbl [9] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

   initial begin
      logic [3:0] exp_ptr;
      logic [3:0] prev_ptr;
      logic [3:0] rd_bin;
      int         lat;

      // Reset held with wr_en=1: every output must stay 0.
      wr_rst = 1'b1; wr_en = 1'b1; ov_clr = 1'b0; rd_ptr = 4'h0;
      tick();
      tick();
      check_all("rst", 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
      wr_rst = 1'b0;
      #1;
      check("rst_release.wr_ram_en", 16'(wr_ram_en), 16'd1);

      // Eight writes with rd_ptr=0.
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp_ptr = GRAY ? gray_tbl[i] : 4'(i);
         check_all($sformatf("fill%0d", i), (i < 8), 3'(i), exp_ptr, (i == 8), (i >= 6), 4'(i), 1'b0);
      end

      // Two writes while full: nothing moves, overflow sets.
      exp_ptr = GRAY ? 4'hC : 4'h8;
      for (int i = 1; i <= 2; i++) begin
         tick();
         check_all($sformatf("ovf_wr%0d", i), 1'b0, 3'd0, exp_ptr, 1'b1, 1'b1, 4'd8, 1'b1);
      end
      wr_en = 1'b0;
      tick();
      tick();
      check("ovf_sticky", 16'(o_overflow), 16'd1);
      ov_clr = 1'b1;
      tick();
      ov_clr = 1'b0;
      check("ovf_clr", 16'(o_overflow), 16'd0);
      // Set and clear in the same cycle: set wins.
      wr_en = 1'b1; ov_clr = 1'b1;
      tick();
      check("ovf_set_wins", 16'(o_overflow), 16'd1);
      wr_en = 1'b0;
      tick();
      ov_clr = 1'b0;
      check("ovf_clr2", 16'(o_overflow), 16'd0);
      check("full_held.wr_ptr", 16'(wr_ptr), 16'(exp_ptr));

      // Read releases one entry: full drops after the synchroniser latency.
      rd_ptr = 4'b0001;
      lat = GRAY ? 3 : 1;
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (k < lat) begin
            check($sformatf("release_wait%0d.full", k), 16'(o_fifo_full), 16'd1);
         end else begin
            check("release.full", 16'(o_fifo_full), 16'd0);
            check("release.level", 16'(o_level), 16'd7);
         end
      end

      // Wrap test: 20 writes with the reader trailing two entries behind.
      wr_rst = 1'b1; rd_ptr = 4'h0;
      #1;
      wr_rst = 1'b0;
      wr_en = 1'b1;
      for (int m = 1; m <= 20; m++) begin
         prev_ptr = wr_ptr;
         tick();
         check($sformatf("wrap%0d.addr", m),  16'(wr_addr), 16'(m % 8));
         check($sformatf("wrap%0d.phase", m), 16'(wr_ptr[3]), 16'((m / 8) % 2));
         check($sformatf("wrap%0d.full", m),  16'(o_fifo_full), 16'd0);
         check($sformatf("wrap%0d.afull", m), 16'(o_almost_full), 16'd0);
         check($sformatf("wrap%0d.level", m), 16'(o_level),
               16'((m < (GRAY ? 5 : 3)) ? m : (GRAY ? 5 : 3)));
`ifdef FIFO_WR_GRAY_EN
         check($sformatf("wrap%0d.onebit", m), 16'($countones(wr_ptr ^ prev_ptr)), 16'd1);
`endif
         rd_bin = (m >= 2) ? 4'(m - 2) : 4'd0;
         rd_ptr = GRAY ? (rd_bin ^ (rd_bin >> 1)) : rd_bin;
      end

      // Reset in the middle of a fill at level 5.
      wr_en = 1'b0; wr_rst = 1'b1; rd_ptr = 4'h0;
      #1;
      wr_rst = 1'b0;
      wr_en = 1'b1;
      for (int i = 1; i <= 5; i++) tick();
      check("midfill.level", 16'(o_level), 16'd5);
      check("midfill.addr", 16'(wr_addr), 16'd5);
      #2;
      wr_rst = 1'b1;
      #1;
      check_all("midrst", 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0);
      tick();
      wr_rst = 1'b0;
      #1;
      check("refill0.addr", 16'(wr_addr), 16'd0);
      check("refill0.wr_ram_en", 16'(wr_ram_en), 16'd1);
      tick();
      check("refill1.addr", 16'(wr_addr), 16'd1);
      check("refill1.level", 16'(o_level), 16'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
